// File: rtl/irrigation_sequencer.sv
// -----------------------------------------------------------------------------
// irrigation_sequencer
//
// Clocked controller for the tank-and-irrigation datapath. Debounces the tank
// level sensors and climate sensors, flags inconsistent level readings, runs
// the tank fill valve with hysteresis and a timeout, and sequences irrigation
// runs through either the sprinkler or the dripper.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous active-low reset
//   enable         1 = automatic operation, 0 = valves closed, FSM parked in IDLE
//   low/mid/high   raw tank level marks (level >= mark)
//   Us / Ua / T    raw soil-dry / air-humid / temperature-high
//   alarm_clr      single-cycle pulse clearing the latched alarm causes
//   watter_supply  fill valve open
//   error          debounced level sensors inconsistent
//   alarme         alarm indicator (error | fill timeout latch | dry-run latch)
//   asp            sprinkler valve open
//   got            dripper valve open
//   state_o        irrigation FSM state code
//
// Irrigation FSM
//   state    | code | meaning
//   ---------+------+-----------------------------------------------------
//   IDLE     |  0   | waiting for dry soil with water above the low mark
//   SPRINKLE |  1   | sprinkler run (air dry and temperature normal)
//   DRIP     |  2   | dripper run (air humid or temperature high)
//   GAP      |  3   | enforced pause between runs
//   FAULT    |  4   | level sensors inconsistent, all valves closed
// -----------------------------------------------------------------------------
module irrigation_sequencer #(
   parameter int DEB_CYCLES     = 4,
   parameter int MAX_IRR_CYCLES = 1000,
   parameter int MIN_GAP_CYCLES = 100,
   parameter int FILL_TIMEOUT   = 5000,
   parameter int CNT_W          = 16
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       enable,
   input  logic       low,
   input  logic       mid,
   input  logic       high,
   input  logic       Us,
   input  logic       Ua,
   input  logic       T,
   input  logic       alarm_clr,
   output logic       watter_supply,
   output logic       error,
   output logic       alarme,
   output logic       asp,
   output logic       got,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_SPRINKLE = 3'd1,
      ST_DRIP     = 3'd2,
      ST_GAP      = 3'd3,
      ST_FAULT    = 3'd4
   } state_t;

   // Terminal counts are compared against "last value before the event", so
   // the event fires on the edge that completes the Nth cycle.
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
   localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(MAX_IRR_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(MIN_GAP_CYCLES - 1);
   localparam logic [CNT_W-1:0] FILL_LAST = CNT_W'(FILL_TIMEOUT - 1);

   localparam int N_DEB = 6;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   // ---------------------------------------------------------------------------
   // Debounce
   // ---------------------------------------------------------------------------
   logic [N_DEB-1:0]            raw;
   logic [N_DEB-1:0]            deb_q, deb_d;
   logic [N_DEB-1:0][CNT_W-1:0] deb_cnt_q, deb_cnt_d;

   assign raw = {T, Ua, Us, high, mid, low};

   always_comb begin
      deb_d     = deb_q;
      deb_cnt_d = deb_cnt_q;
      for (int i = 0; i < N_DEB; i++) begin
         if (raw[i] == deb_q[i]) begin
            deb_cnt_d[i] = '0;
         end else if (deb_cnt_q[i] >= DEB_LAST) begin
            deb_d[i]     = raw[i];
            deb_cnt_d[i] = '0;
         end else begin
            deb_cnt_d[i] = sat_inc(deb_cnt_q[i]);
         end
      end
   end

   logic low_db, mid_db, high_db, us_db, ua_db, t_db;
   assign low_db  = deb_q[0];
   assign mid_db  = deb_q[1];
   assign high_db = deb_q[2];
   assign us_db   = deb_q[3];
   assign ua_db   = deb_q[4];
   assign t_db    = deb_q[5];

   // ---------------------------------------------------------------------------
   // Consistency check
   // ---------------------------------------------------------------------------
   logic error_q, error_d;
   assign error_d = (mid_db & ~low_db) | (high_db & ~mid_db);

   // ---------------------------------------------------------------------------
   // Fill control
   // ---------------------------------------------------------------------------
   logic             ws_q, ws_d;
   logic [CNT_W-1:0] fill_cnt_q, fill_cnt_d;
   logic             fill_to_q, fill_to_d;
   logic             fill_hit;

   assign fill_hit = ws_q & (fill_cnt_q >= FILL_LAST);

   always_comb begin
      ws_d = ws_q;
      if (error_d | ~enable | high_db | fill_to_q | fill_hit) begin
         ws_d = 1'b0;
      end else if (~mid_db) begin
         ws_d = 1'b1;
      end
      // Counter only runs across consecutive open cycles; any close restarts it.
      fill_cnt_d = (ws_q & ws_d) ? sat_inc(fill_cnt_q) : '0;
      fill_to_d  = fill_hit | (fill_to_q & ~alarm_clr);
   end

   // ---------------------------------------------------------------------------
   // Irrigation FSM
   // ---------------------------------------------------------------------------
   state_t           state_q, state_d;
   logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
   logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
   logic             dry_q, dry_d;
   logic             dry_set;
   logic             start_ok;

   assign start_ok = enable & us_db & low_db;

   // FAULT is keyed off the value error is about to take, so the valves drop
   // on the same edge that error rises.
   always_comb begin
      state_d   = state_q;
      run_cnt_d = run_cnt_q;
      gap_cnt_d = gap_cnt_q;
      dry_set   = 1'b0;
      if (error_d) begin
         state_d = ST_FAULT;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  // Valve type is chosen here and never revisited mid-run.
                  state_d   = (ua_db | t_db) ? ST_DRIP : ST_SPRINKLE;
                  run_cnt_d = '0;
               end
            end
            ST_SPRINKLE, ST_DRIP: begin
               if (~us_db | ~enable | (run_cnt_q >= RUN_LAST)) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
               end else if (~low_db) begin
                  state_d   = ST_GAP;
                  gap_cnt_d = '0;
                  dry_set   = 1'b1;
               end else begin
                  run_cnt_d = sat_inc(run_cnt_q);
               end
            end
            ST_GAP: begin
               if (~enable | (gap_cnt_q >= GAP_LAST)) begin
                  state_d = ST_IDLE;
               end else begin
                  gap_cnt_d = sat_inc(gap_cnt_q);
               end
            end
            ST_FAULT: begin
               state_d   = ST_GAP;
               gap_cnt_d = '0;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   assign dry_d = dry_set | (dry_q & ~alarm_clr);

   // ---------------------------------------------------------------------------
   // Output registers
   // ---------------------------------------------------------------------------
   logic asp_q, got_q, alarme_q;
   logic asp_d, got_d, alarme_d;

   assign asp_d    = (state_d == ST_SPRINKLE);
   assign got_d    = (state_d == ST_DRIP);
   assign alarme_d = error_d | fill_to_d | dry_d;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         deb_q      <= '0;
         deb_cnt_q  <= '0;
         error_q    <= 1'b0;
         ws_q       <= 1'b0;
         fill_cnt_q <= '0;
         fill_to_q  <= 1'b0;
         state_q    <= ST_IDLE;
         run_cnt_q  <= '0;
         gap_cnt_q  <= '0;
         dry_q      <= 1'b0;
         asp_q      <= 1'b0;
         got_q      <= 1'b0;
         alarme_q   <= 1'b0;
      end else begin
         deb_q      <= deb_d;
         deb_cnt_q  <= deb_cnt_d;
         error_q    <= error_d;
         ws_q       <= ws_d;
         fill_cnt_q <= fill_cnt_d;
         fill_to_q  <= fill_to_d;
         state_q    <= state_d;
         run_cnt_q  <= run_cnt_d;
         gap_cnt_q  <= gap_cnt_d;
         dry_q      <= dry_d;
         asp_q      <= asp_d;
         got_q      <= got_d;
         alarme_q   <= alarme_d;
      end
   end

   assign watter_supply = ws_q;
   assign error         = error_q;
   assign alarme        = alarme_q;
   assign asp           = asp_q;
   assign got           = got_q;
   assign state_o       = state_q;

endmodule

// File: tb/tb_irrigation_sequencer.sv
module tb_irrigation_sequencer;

   logic       clk;
   logic       reset_n;
   logic       en, lo_in, mi_in, hi_in, us_in, ua_in, t_in, clr;
   logic       ws, err, alm, asp, got;
   logic [2:0] st;

   int checks = 0;
   int errors = 0;

   irrigation_sequencer #(
      .DEB_CYCLES     (2),
      .MAX_IRR_CYCLES (10),
      .MIN_GAP_CYCLES (5),
      .FILL_TIMEOUT   (20),
      .CNT_W          (16)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .enable        (en),
      .low           (lo_in),
      .mid           (mi_in),
      .high          (hi_in),
      .Us            (us_in),
      .Ua            (ua_in),
      .T             (t_in),
      .alarm_clr     (clr),
      .watter_supply (ws),
      .error         (err),
      .alarme        (alm),
      .asp           (asp),
      .got           (got),
      .state_o       (st)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit en, lo, mi, hi, us, ua, t, clr;
      int n;
      bit ws, err, alm, asp, got;
      bit [2:0] st;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs[NV];

   function automatic vec_t mk(input bit e, input bit l, input bit m, input bit h,
                               input bit u, input bit a, input bit tt, input bit c,
                               input int n,
                               input bit w, input bit er, input bit al,
                               input bit sp, input bit dr, input bit [2:0] s);
      vec_t v;
      v.en = e; v.lo = l; v.mi = m; v.hi = h; v.us = u; v.ua = a; v.t = tt; v.clr = c;
      v.n = n;
      v.ws = w; v.err = er; v.alm = al; v.asp = sp; v.got = dr; v.st = s;
      return v;
   endfunction

   task automatic chk(input string nm, input int idx, input logic [2:0] act, input logic [2:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s[%0d]: actual %0d expected %0d", nm, idx, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input int idx,
                          input bit e_ws, input bit e_err, input bit e_alm,
                          input bit e_asp, input bit e_got, input bit [2:0] e_st);
      chk({tag, ".watter_supply"}, idx, {2'b0, ws},  {2'b0, e_ws});
      chk({tag, ".error"},         idx, {2'b0, err}, {2'b0, e_err});
      chk({tag, ".alarme"},        idx, {2'b0, alm}, {2'b0, e_alm});
      chk({tag, ".asp"},           idx, {2'b0, asp}, {2'b0, e_asp});
      chk({tag, ".got"},           idx, {2'b0, got}, {2'b0, e_got});
      chk({tag, ".state_o"},       idx, st,          e_st);
   endtask

   function automatic bit [2:0] seq_a_state(input int e);
      if (e < 3)   return 3'd0;
      if (e <= 12) return 3'd1;
      if (e <= 17) return 3'd3;
      if (e == 18) return 3'd0;
      return 3'd1;
   endfunction

   initial begin
      //            en lo mi hi us ua t clr  n   ws er al sp dr st
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0,  2,  0, 0, 0, 0, 0, 3'd0);
      vecs[1]  = mk(0, 1, 1, 0, 0, 0, 0, 0,  3,  0, 0, 0, 0, 0, 3'd0);
      // dripper run, soil turns wet part-way through
      vecs[2]  = mk(1, 1, 1, 0, 1, 0, 1, 0,  3,  0, 0, 0, 0, 1, 3'd2);
      vecs[3]  = mk(1, 1, 1, 0, 1, 0, 1, 0,  3,  0, 0, 0, 0, 1, 3'd2);
      vecs[4]  = mk(1, 1, 1, 0, 0, 0, 1, 0,  2,  0, 0, 0, 0, 1, 3'd2);
      vecs[5]  = mk(1, 1, 1, 0, 0, 0, 1, 0,  1,  0, 0, 0, 0, 0, 3'd3);
      vecs[6]  = mk(1, 1, 1, 0, 0, 0, 1, 0,  4,  0, 0, 0, 0, 0, 3'd3);
      vecs[7]  = mk(1, 1, 1, 0, 0, 0, 1, 0,  1,  0, 0, 0, 0, 0, 3'd0);
      // fill hysteresis
      vecs[8]  = mk(1, 1, 0, 0, 0, 0, 0, 0,  3,  1, 0, 0, 0, 0, 3'd0);
      vecs[9]  = mk(1, 1, 1, 0, 0, 0, 0, 0,  3,  1, 0, 0, 0, 0, 3'd0);
      vecs[10] = mk(1, 1, 1, 1, 0, 0, 0, 0,  3,  0, 0, 0, 0, 0, 3'd0);
      vecs[11] = mk(1, 1, 1, 0, 0, 0, 0, 0,  3,  0, 0, 0, 0, 0, 3'd0);
      // fill timeout
      vecs[12] = mk(1, 1, 0, 0, 0, 0, 0, 0,  3,  1, 0, 0, 0, 0, 3'd0);
      vecs[13] = mk(1, 1, 0, 0, 0, 0, 0, 0, 19,  1, 0, 0, 0, 0, 3'd0);
      vecs[14] = mk(1, 1, 0, 0, 0, 0, 0, 0,  1,  0, 0, 1, 0, 0, 3'd0);
      vecs[15] = mk(1, 1, 0, 0, 0, 0, 0, 0,  5,  0, 0, 1, 0, 0, 3'd0);
      vecs[16] = mk(1, 1, 0, 0, 0, 0, 0, 1,  1,  0, 0, 0, 0, 0, 3'd0);
      vecs[17] = mk(1, 1, 0, 0, 0, 0, 0, 0,  1,  1, 0, 0, 0, 0, 3'd0);
      // inconsistent levels during a dripper run
      vecs[18] = mk(1, 1, 1, 1, 0, 0, 0, 0,  3,  0, 0, 0, 0, 0, 3'd0);
      vecs[19] = mk(1, 1, 1, 1, 1, 0, 1, 0,  3,  0, 0, 0, 0, 1, 3'd2);
      vecs[20] = mk(1, 1, 0, 1, 1, 0, 1, 0,  3,  0, 1, 1, 0, 0, 3'd4);
      vecs[21] = mk(1, 1, 1, 1, 1, 0, 1, 0,  2,  0, 1, 1, 0, 0, 3'd4);
      vecs[22] = mk(1, 1, 1, 1, 1, 0, 1, 0,  1,  0, 0, 0, 0, 0, 3'd3);
      vecs[23] = mk(1, 1, 1, 1, 0, 0, 0, 0,  4,  0, 0, 0, 0, 0, 3'd3);
      vecs[24] = mk(1, 1, 1, 1, 0, 0, 0, 0,  1,  0, 0, 0, 0, 0, 3'd0);
      // tank runs dry during a sprinkler run while filling
      vecs[25] = mk(1, 1, 0, 0, 1, 0, 0, 0,  3,  1, 0, 0, 1, 0, 3'd1);
      vecs[26] = mk(1, 0, 0, 0, 1, 0, 0, 0,  3,  1, 0, 1, 0, 0, 3'd3);
      vecs[27] = mk(1, 0, 0, 0, 1, 0, 0, 0,  3,  1, 0, 1, 0, 0, 3'd3);
      vecs[28] = mk(1, 0, 0, 0, 1, 0, 0, 0,  2,  1, 0, 1, 0, 0, 3'd0);
      vecs[29] = mk(1, 0, 0, 0, 1, 0, 0, 1,  1,  1, 0, 0, 0, 0, 3'd0);
      vecs[30] = mk(0, 0, 0, 0, 1, 0, 0, 0,  1,  0, 0, 0, 0, 0, 3'd0);

      // reset with all inputs quiet
      reset_n = 1'b0;
      en = 0; lo_in = 0; mi_in = 0; hi_in = 0; us_in = 0; ua_in = 0; t_in = 0; clr = 0;
      #3;
      chk_all("reset", 0, 0, 0, 0, 0, 0, 3'd0);
      #19 reset_n = 1'b1;
      @(posedge clk); #1;
      chk_all("post_reset", 0, 0, 0, 0, 0, 0, 3'd0);

      // sprinkler cycle from a cold start: run, gap, restart
      en = 1; lo_in = 1; mi_in = 1; hi_in = 0; us_in = 1; ua_in = 0; t_in = 0;
      for (int e = 1; e <= 19; e++) begin
         bit [2:0] s;
         @(posedge clk); #1;
         s = seq_a_state(e);
         // the fill valve opens on the first edge, before mid is debounced
         chk_all("seq_a", e, 1, 0, 0, (s == 3'd1), 0, s);
      end

      // asynchronous reset in the middle of a run and fill
      #2 reset_n = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 0, 0, 0, 3'd0);
      en = 0; lo_in = 0; mi_in = 0; hi_in = 0; us_in = 0; ua_in = 0; t_in = 0; clr = 0;
      #2 reset_n = 1'b1;

      for (int i = 0; i < NV; i++) begin
         en    = vecs[i].en;
         lo_in = vecs[i].lo;
         mi_in = vecs[i].mi;
         hi_in = vecs[i].hi;
         us_in = vecs[i].us;
         ua_in = vecs[i].ua;
         t_in  = vecs[i].t;
         clr   = vecs[i].clr;
         repeat (vecs[i].n) @(posedge clk);
         #1;
         chk_all("vec", i, vecs[i].ws, vecs[i].err, vecs[i].alm,
                 vecs[i].asp, vecs[i].got, vecs[i].st);
         if (asp && got) begin
            errors++;
            $display("FAIL exclusive_valves[%0d]: actual asp=%0b got=%0b required not both 1", i, asp, got);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/irrigation_sequencer.md
Name: irrigation_sequencer

Overview:
- Clocked controller for the tank-and-irrigation datapath.
- Debounces the tank level sensors (low/mid/high) and the climate sensors (Us soil-dry, Ua air-humid, T temperature-high).
- Detects inconsistent level readings.
- Runs the tank fill valve with hysteresis and a fill timeout.
- Sequences irrigation through either the sprinkler or the dripper, with a maximum run time and a minimum gap between runs.
- Replaces the purely combinational selection path at the top level.

Parameters:
DEB_CYCLES, 4, cycles an input must hold a new value before the debounced copy changes (≥1)
MAX_IRR_CYCLES, 1000, maximum cycles of one irrigation run
MIN_GAP_CYCLES, 100, cycles the sequencer waits after a run before a new one may start
FILL_TIMEOUT, 5000, maximum cycles watter_supply may stay open continuously
CNT_W, 16, width of every internal counter; must hold the largest parameter value

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = automatic operation; 0 = close all valves, FSM held in IDLE
low  in  1  level ≥ low mark
mid  in  1  level ≥ mid mark
high  in  1  level ≥ high mark
Us  in  1  soil dry
Ua  in  1  air humid
T  in  1  temperature high
alarm_clr  in  1  single-cycle pulse; clears latched alarm causes
watter_supply  out  1  fill valve open
error  out  1  debounced level sensors inconsistent
alarme  out  1  alarm indicator
asp  out  1  sprinkler valve open
got  out  1  dripper valve open
state_o  out  3  irrigation FSM state code

Behaviour:
- Reset (async assert, sync release):
  - all outputs 0; state_o = IDLE;
  - all debounced copies 0; all counters 0; alarm latches 0.
- Debounce, per input (low, mid, high, Us, Ua, T):
  - a counter increments while raw ≠ debounced and resets to 0 on raw = debounced;
  - the debounced copy takes the raw value when the counter reaches DEB_CYCLES−1;
  - latency from a stable change to the debounced change is DEB_CYCLES cycles.
- Consistency check:
  - error (registered, 1 cycle after the debounced inputs) = (mid & ~low) | (high & ~mid);
  - while error = 1: watter_supply = asp = got = 0.
- Fill control, with registered watter_supply:
  - set when ~error & enable & ~mid;
  - cleared when high | error | ~enable;
  - otherwise holds (hysteresis band from mid to high).
  - A fill counter counts cycles while watter_supply = 1 and clears when the valve closes.
  - On reaching FILL_TIMEOUT the valve is forced to 0 and fill_to_latch is set.
  - Once fill_to_latch is set, the valve cannot reopen until alarm_clr.
- Irrigation FSM, state_o codes: IDLE=0, SPRINKLE=1, DRIP=2, GAP=3, FAULT=4. Transitions are evaluated in order, first match wins:
  - any state → FAULT when error = 1.
  - FAULT → GAP when error = 0; the gap counter restarts.
  - IDLE → SPRINKLE when enable & Us & low & ~Ua & ~T.
  - IDLE → DRIP when enable & Us & low & (Ua | T).
  - SPRINKLE/DRIP → GAP when ~Us (soil wet), ~enable, or the run counter reaches MAX_IRR_CYCLES.
  - SPRINKLE/DRIP → GAP when ~low; this is an abort and also sets dry_latch.
  - The run counter starts at 0 on entry.
  - The valve choice is fixed at run start; Ua/T changes mid-run are ignored.
  - GAP → IDLE when the gap counter reaches MIN_GAP_CYCLES. With ~enable, GAP goes to IDLE immediately.
- Valve outputs are registered from the next state:
  - asp = 1 only in SPRINKLE; got = 1 only in DRIP;
  - asp and got are never both 1;
  - they assert 1 cycle after the start condition is debounced.
- Fill and irrigation may be active simultaneously.
- alarme (registered) = error | fill_to_latch | dry_latch.
  - alarm_clr clears both latches in the next cycle.
  - If a latch condition and alarm_clr occur in the same cycle, the set wins.
- Counters saturate and never wrap.

Test Plan:
Use DEB_CYCLES=2, MAX_IRR_CYCLES=10, MIN_GAP_CYCLES=5, FILL_TIMEOUT=20.
- Reset, then low=mid=1, high=0, Us=1, Ua=T=0, enable=1 → asp=1 3 cycles after the inputs become stable; got=0; asp stays 10 cycles; then state_o=3 for 5 cycles; then SPRINKLE again.
- Us=1, T=1, low=1 → got=1, asp=0.
  - Drop Us at cycle 4 of the run → got=0 2–3 cycles later; state_o=3.
- low=1, mid=0, high=0 → watter_supply=1.
  - Raise mid → the valve stays 1.
  - Raise high → the valve goes 0.
  - Lower high only → the valve stays 0.
- Hold mid=0, high=0 for 25 cycles → watter_supply drops after 20 open cycles; alarme=1; the valve stays closed until an alarm_clr pulse, then reopens.
- high=1, mid=0, during DRIP → error=1, got=0, watter_supply=0, alarme=1, state_o=4.
  - Restore consistency → state_o=3, then 0.
- Drop low during SPRINKLE → asp=0; alarme=1 (dry_latch) persists until alarm_clr.
- Assert reset_n=0 mid-run → all outputs 0 immediately, without waiting for a clock edge.
